// File: rtl/autotest_sweep.sv
// autotest_sweep: sweeps the sdspi read engine over speed, block count and read mode, timing each run
module autotest_sweep #(
  parameter int          NB_W       = 32,
  parameter int          SPD_W      = 5,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] TIMEOUT    = 32'h00FF_FFFF,
  parameter int          RST_CYCLES = 16,
  parameter bit          BOTH_MODES = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [SPD_W-1:0] cfg_speed_min,
  input  logic [SPD_W-1:0] cfg_speed_max,
  input  logic [NB_W-1:0]  cfg_nb_start,
  input  logic [NB_W-1:0]  cfg_nb_step,
  input  logic [7:0]       cfg_nb_steps,
  input  logic             cfg_cmd18,
  output logic             sdspi_ctrl_mux,
  output logic             sdspi_rst,
  output logic             sdspi_start,
  output logic [NB_W-1:0]  sdspi_n_blocks,
  output logic [SPD_W-1:0] sdspi_sclk_speed,
  output logic             sdspi_cmd18,
  input  logic             sdspi_finish,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_cycles,
  output logic [SPD_W-1:0] res_speed,
  output logic [NB_W-1:0]  res_n_blocks,
  output logic             res_cmd18,
  output logic             res_timeout,
  output logic             busy,
  output logic             done
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
  typedef enum logic [2:0] {IDLE, URST, GO, RUN, REPORT, NEXT, FIN} state_t;
  state_t           state_q, state_d;
  logic [SPD_W-1:0] spd_q, spd_d, spd_max_q, spd_max_d;
  logic [NB_W-1:0]  nb_q, nb_d, nb_start_q, nb_start_d, nb_step_q, nb_step_d;
  logic [7:0]       steps_q, steps_d, idx_q, idx_d;
  logic             mode_q, mode_d, cmd18_cfg_q, cmd18_cfg_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cyc_q, cyc_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             fixed_mode;
  assign cnt_inc    = cnt_q + 1'b1;
  assign fixed_mode = BOTH_MODES ? 1'b0 : cmd18_cfg_q;
  // Next-state: run sequencing, latency measurement and the innermost-first sweep walk
  always_comb begin
    state_d     = state_q;
    spd_d       = spd_q;
    spd_max_d   = spd_max_q;
    nb_d        = nb_q;
    nb_start_d  = nb_start_q;
    nb_step_d   = nb_step_q;
    steps_d     = steps_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    cmd18_cfg_d = cmd18_cfg_q;
    rcnt_d      = '0;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    to_d        = to_q;
    case (state_q)
      IDLE: if (start) begin
        spd_d       = cfg_speed_min;
        spd_max_d   = cfg_speed_max;
        nb_d        = cfg_nb_start;
        nb_start_d  = cfg_nb_start;
        nb_step_d   = cfg_nb_step;
        steps_d     = cfg_nb_steps;
        idx_d       = '0;
        cmd18_cfg_d = cfg_cmd18;
        mode_d      = BOTH_MODES ? 1'b0 : cfg_cmd18;
        state_d     = (cfg_speed_min > cfg_speed_max || cfg_nb_steps == 8'd0) ? FIN : URST;
      end
      URST: begin
        rcnt_d  = rcnt_q + 1'b1;
        state_d = (rcnt_q == RW'(RST_CYCLES - 1)) ? GO : URST;
      end
      GO: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (sdspi_finish || cnt_inc == TO) begin
          cyc_d   = cnt_inc;
          to_d    = !sdspi_finish;
          state_d = REPORT;
        end
      end
      REPORT: state_d = res_ready ? NEXT : REPORT;
      NEXT: begin
        state_d = URST;
        if (BOTH_MODES && !mode_q) mode_d = 1'b1;
        else begin
          mode_d = fixed_mode;
          if ({1'b0, idx_q} + 9'd1 < {1'b0, steps_q}) begin
            idx_d = idx_q + 8'd1;
            nb_d  = nb_q + nb_step_q;
          end else begin
            idx_d = '0;
            nb_d  = nb_start_q;
            if (spd_q == spd_max_q) state_d = FIN;
            else spd_d = spd_q + 1'b1;
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE && state_q != FIN) state_d = FIN;
  end
  // State and sweep registers; asynchronous reset returns everything to idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      spd_q       <= '0;
      spd_max_q   <= '0;
      nb_q        <= '0;
      nb_start_q  <= '0;
      nb_step_q   <= '0;
      steps_q     <= '0;
      idx_q       <= '0;
      mode_q      <= 1'b0;
      cmd18_cfg_q <= 1'b0;
      rcnt_q      <= '0;
      cnt_q       <= '0;
      cyc_q       <= '0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      spd_q       <= spd_d;
      spd_max_q   <= spd_max_d;
      nb_q        <= nb_d;
      nb_start_q  <= nb_start_d;
      nb_step_q   <= nb_step_d;
      steps_q     <= steps_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      cmd18_cfg_q <= cmd18_cfg_d;
      rcnt_q      <= rcnt_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      to_q        <= to_d;
    end
  end
  assign busy             = state_q != IDLE;
  assign sdspi_ctrl_mux   = state_q != IDLE;
  assign sdspi_rst        = state_q inside {IDLE, URST, FIN};
  assign sdspi_start      = state_q == GO;
  assign done             = state_q == FIN;
  assign res_valid        = state_q == REPORT && !abort;
  assign sdspi_n_blocks   = nb_q;
  assign sdspi_sclk_speed = spd_q;
  assign sdspi_cmd18      = mode_q;
  assign res_cycles       = cyc_q;
  assign res_timeout      = to_q;
  assign res_speed        = spd_q;
  assign res_n_blocks     = nb_q;
  assign res_cmd18        = mode_q;
endmodule

// File: tb/tb_autotest_sweep.sv
// tb_autotest_sweep: directed checks of autotest_sweep with a latency-programmable UUT model
module tb_autotest_sweep;
  logic        clk = 1'b0, rst = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, abort = 1'b0, res_ready = 1'b1;
  logic [4:0]  cfg_speed_min = '0, cfg_speed_max = '0;
  logic [31:0] cfg_nb_start = '0, cfg_nb_step = '0;
  logic [7:0]  cfg_nb_steps = '0;
  logic        cfg_cmd18 = 1'b0;
  logic        sel = 1'b0, fin_en = 1'b1;
  int          lat = 100;
  int          errors = 0, checks = 0;
  int          nrec = 0, ndone = 0, nstart = 0, run_len = 0, rst_len = 0;
  int          uca = 0, ucb = 0;
  logic a_mux, a_srst, a_start, a_c18, a_valid, a_cmd18, a_to, a_busy, a_done, a_fin;
  logic b_mux, b_srst, b_start, b_c18, b_valid, b_cmd18, b_to, b_busy, b_done, b_fin;
  logic [31:0] a_nbo, a_nb, a_cyc, b_nbo, b_nb, b_cyc;
  logic [4:0]  a_spo, a_spd, b_spo, b_spd;

  autotest_sweep #(.BOTH_MODES(1'b0)) ua (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort),
    .cfg_speed_min(cfg_speed_min), .cfg_speed_max(cfg_speed_max),
    .cfg_nb_start(cfg_nb_start), .cfg_nb_step(cfg_nb_step), .cfg_nb_steps(cfg_nb_steps),
    .cfg_cmd18(cfg_cmd18), .sdspi_ctrl_mux(a_mux), .sdspi_rst(a_srst), .sdspi_start(a_start),
    .sdspi_n_blocks(a_nbo), .sdspi_sclk_speed(a_spo), .sdspi_cmd18(a_c18), .sdspi_finish(a_fin),
    .res_valid(a_valid), .res_ready(res_ready), .res_cycles(a_cyc), .res_speed(a_spd),
    .res_n_blocks(a_nb), .res_cmd18(a_cmd18), .res_timeout(a_to), .busy(a_busy), .done(a_done));

  autotest_sweep #(.TIMEOUT(32'd50), .BOTH_MODES(1'b1)) ub (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort),
    .cfg_speed_min(cfg_speed_min), .cfg_speed_max(cfg_speed_max),
    .cfg_nb_start(cfg_nb_start), .cfg_nb_step(cfg_nb_step), .cfg_nb_steps(cfg_nb_steps),
    .cfg_cmd18(cfg_cmd18), .sdspi_ctrl_mux(b_mux), .sdspi_rst(b_srst), .sdspi_start(b_start),
    .sdspi_n_blocks(b_nbo), .sdspi_sclk_speed(b_spo), .sdspi_cmd18(b_c18), .sdspi_finish(b_fin),
    .res_valid(b_valid), .res_ready(res_ready), .res_cycles(b_cyc), .res_speed(b_spd),
    .res_n_blocks(b_nb), .res_cmd18(b_cmd18), .res_timeout(b_to), .busy(b_busy), .done(b_done));

  always #5 clk = ~clk;

  // UUT models: finish rises lat cycles after the start pulse and holds until the UUT is reset
  always @(posedge clk) begin
    uca <= (!rst || a_srst) ? 0 : a_start ? 1 : (uca != 0 && uca < 100000) ? uca + 1 : uca;
    ucb <= (!rst || b_srst) ? 0 : b_start ? 1 : (ucb != 0 && ucb < 100000) ? ucb + 1 : ucb;
  end
  assign a_fin = fin_en && uca != 0 && uca >= lat;
  assign b_fin = fin_en && ucb != 0 && ucb >= lat;

  wire        o_valid = sel ? b_valid : a_valid;
  wire        o_start = sel ? b_start : a_start;
  wire        o_done  = sel ? b_done  : a_done;
  wire        o_busy  = sel ? b_busy  : a_busy;
  wire        o_srst  = sel ? b_srst  : a_srst;
  wire        o_mux   = sel ? b_mux   : a_mux;
  wire [70:0] cur = sel ? {b_spd, b_nb, b_cmd18, b_to, b_cyc} : {a_spd, a_nb, a_cmd18, a_to, a_cyc};

  // Event monitors: accepted records, done pulses, start pulses, UUT reset length before each start
  always @(negedge clk) begin
    if (o_valid && res_ready) nrec++;
    if (o_done) ndone++;
    if (o_start) begin nstart++; rst_len = run_len; run_len = 0; end
    else if (o_busy && o_srst) run_len++;
    else run_len = 0;
  end

  function automatic logic [70:0] mk(logic [4:0] s, logic [31:0] nb, logic m, logic t, logic [31:0] c);
    return {s, nb, m, t, c};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go(input bit b, input logic [4:0] smin, input logic [4:0] smax,
                    input logic [31:0] nbs, input logic [31:0] nst, input logic [7:0] stp, input logic c18);
    @(negedge clk);
    cfg_speed_min = smin; cfg_speed_max = smax; cfg_nb_start = nbs;
    cfg_nb_step = nst; cfg_nb_steps = stp; cfg_cmd18 = c18;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic wait_valid(input int lim, input string tag);
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (o_valid) return;
    end
    chk({tag, "_wait_valid"}, 0, 1);
  endtask

  task automatic wait_done(input int lim, input string tag);
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (o_done) return;
    end
    chk({tag, "_wait_done"}, 0, 1);
  endtask

  task automatic wait_start(input int lim, input string tag);
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (o_start) return;
    end
    chk({tag, "_wait_start"}, 0, 1);
  endtask

  task automatic get_rec(input int lim, input string tag, output logic [70:0] r);
    wait_valid(lim, tag);
    r = cur;
  endtask

  logic [70:0] r, r0;
  int n0, d0, s0;
  bit stable;

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_srst", o_srst, 1);
    chk("rst_mux", o_mux, 0);
    chk("rst_busy_done_start_valid", {o_busy, o_done, o_start, o_valid}, 0);
    chk("rst_res", cur, 0);
    chk("rst_sdspi_fields", {a_nbo, a_spo, a_c18}, 0);
    tick(1); rst = 1'b1; tick(2);

    // single point, fixed mode cmd18=1
    d0 = ndone; n0 = nrec;
    go(0, 5'd3, 5'd3, 32'd8, 32'd0, 8'd1, 1'b1);
    get_rec(300, "single", r);
    chk("single_rec", r, mk(5'd3, 32'd8, 1'b1, 1'b0, 32'd100));
    chk("single_rst_len", rst_len, 16);
    wait_done(10, "single");
    tick(3);
    chk("single_done_count", ndone - d0, 1);
    chk("single_rec_count", nrec - n0, 1);
    chk("single_idle", {o_busy, o_srst}, 2'b01);

    // backpressure
    lat = 10; res_ready = 1'b0;
    go(0, 5'd7, 5'd7, 32'd20, 32'd0, 8'd1, 1'b0);
    wait_valid(100, "bp");
    r0 = cur; s0 = nstart; stable = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (!o_valid || cur !== r0) stable = 1'b0;
    end
    chk("bp_rec", r0, mk(5'd7, 32'd20, 1'b0, 1'b0, 32'd10));
    chk("bp_stable", stable, 1);
    chk("bp_no_start", nstart - s0, 0);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_accepted", o_valid, 0);
    wait_done(5, "bp");

    // empty sweep: min > max
    lat = 3; n0 = nrec;
    go(0, 5'd5, 5'd4, 32'd1, 32'd1, 8'd1, 1'b0);
    wait_done(2, "empty");
    tick(3);
    chk("empty_no_rec", nrec - n0, 0);

    // top speed terminates without wrapping
    go(0, 5'd30, 5'd31, 32'd3, 32'd0, 8'd1, 1'b0);
    get_rec(100, "max31a", r);
    chk("max31_rec0", r, mk(5'd30, 32'd3, 1'b0, 1'b0, 32'd3));
    get_rec(100, "max31b", r);
    chk("max31_rec1", r, mk(5'd31, 32'd3, 1'b0, 1'b0, 32'd3));
    wait_done(10, "max31");
    tick(2);
    chk("max31_idle", o_busy, 0);

    // block count wraps modulo 2^32
    go(0, 5'd1, 5'd1, 32'hFFFF_FFFF, 32'd2, 8'd2, 1'b0);
    get_rec(100, "wrap0", r);
    chk("wrap_rec0", r, mk(5'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd3));
    get_rec(100, "wrap1", r);
    chk("wrap_rec1", r, mk(5'd1, 32'd1, 1'b0, 1'b0, 32'd3));
    wait_done(10, "wrap");

    // abort during RUN
    lat = 100; n0 = nrec;
    go(0, 5'd3, 5'd3, 32'd8, 32'd0, 8'd1, 1'b0);
    wait_start(50, "abort_run");
    tick(5);
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    chk("abort_run_done_srst", {o_done, o_srst}, 2'b11);
    @(negedge clk);
    chk("abort_run_idle", {o_busy, o_done}, 0);
    tick(2);
    chk("abort_run_no_rec", nrec - n0, 0);

    // abort while a record is pending
    lat = 4; res_ready = 1'b0; n0 = nrec;
    go(0, 5'd3, 5'd3, 32'd8, 32'd0, 8'd1, 1'b0);
    wait_valid(100, "abort_rep");
    abort = 1'b1; #1;
    chk("abort_rep_valid_drop", o_valid, 0);
    @(posedge clk); #1; abort = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    chk("abort_rep_done", o_done, 1);
    tick(3);
    chk("abort_rep_no_rec", nrec - n0, 0);

    // asynchronous reset in the middle of URST
    go(0, 5'd3, 5'd3, 32'd8, 32'd0, 8'd1, 1'b0);
    tick(5);
    chk("mid_urst_busy", {o_busy, o_srst, o_mux}, 3'b111);
    rst = 1'b0; #1;
    chk("mid_urst_reset", {o_busy, o_mux, o_srst, o_valid, o_done, o_start}, 6'b001000);
    tick(1); rst = 1'b1; tick(3);
    chk("mid_urst_stays_idle", o_busy, 0);

    // full sweep with both modes
    sel = 1'b1; lat = 5; n0 = nrec;
    go(1, 5'd2, 5'd4, 32'd1, 32'd4, 8'd3, 1'b0);
    for (int s = 2; s <= 4; s++)
      for (int i = 0; i < 3; i++)
        for (int m = 0; m < 2; m++) begin
          get_rec(100, "sweep", r);
          chk("sweep_rec", r, mk(5'(s), 32'(1 + 4 * i), m[0], 1'b0, 32'd5));
        end
    wait_done(10, "sweep");
    tick(2);
    chk("sweep_rec_count", nrec - n0, 18);

    // timeout, sweep continues
    fin_en = 1'b0;
    go(1, 5'd0, 5'd0, 32'd2, 32'd1, 8'd2, 1'b0);
    for (int i = 0; i < 2; i++)
      for (int m = 0; m < 2; m++) begin
        get_rec(200, "timeout", r);
        chk("timeout_rec", r, mk(5'd0, 32'(2 + i), m[0], 1'b1, 32'd50));
      end
    wait_done(10, "timeout");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/autotest_sweep.md
Name: autotest_sweep

Overview:
- Parametrised successor of the single-shot SD-SPI autotest controller.
- Autonomously sweeps the UUT (sdspi read engine) over a range of sclk speeds, block counts and read modes (CMD17-loop / CMD18).
- Per run: resets the UUT, starts it, measures completion latency in clk cycles with a timeout, and emits one result record over a valid/ready handshake.
- Sits between the test-control FSM (which supplies sweep limits) and the UUT control mux.

Parameters:
- NB_W, 32, width of sdspi_n_blocks and the block-count arithmetic.
- SPD_W, 5, width of sdspi_sclk_speed.
- CNT_W, 32, width of the latency counter and result_cycles.
- TIMEOUT, 32'h00FF_FFFF, maximum cycles waited for sdspi_finish per run.
- RST_CYCLES, 16, number of cycles sdspi_rst is held per run (must be >= 1).
- BOTH_MODES, 1, 1 = run each point with cmd18=0 then cmd18=1; 0 = cmd18 fixed to cfg_cmd18.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  sweep request; sampled only in IDLE
- abort  in  1  synchronous abort of a running sweep
- cfg_speed_min  in  SPD_W  first sclk speed
- cfg_speed_max  in  SPD_W  last sclk speed (inclusive)
- cfg_nb_start  in  NB_W  first block count
- cfg_nb_step  in  NB_W  block-count increment
- cfg_nb_steps  in  8  number of block-count points per speed
- cfg_cmd18  in  1  mode used when BOTH_MODES=0
- sdspi_ctrl_mux  out  1  1 = tester owns the UUT controls
- sdspi_rst  out  1  UUT reset, active-high
- sdspi_start  out  1  UUT start pulse
- sdspi_n_blocks  out  NB_W  current block count
- sdspi_sclk_speed  out  SPD_W  current speed
- sdspi_cmd18  out  1  current mode
- sdspi_finish  in  1  UUT completion level
- res_valid  out  1  result record valid
- res_ready  in  1  consumer accepts the record
- res_cycles  out  CNT_W  measured latency
- res_speed  out  SPD_W  speed of the run
- res_n_blocks  out  NB_W  block count of the run
- res_cmd18  out  1  mode of the run
- res_timeout  out  1  run hit TIMEOUT
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end

Behaviour:
- Reset (rst=0): state IDLE. All outputs are 0, except sdspi_rst=1 (UUT held in reset).
- IDLE:
  - sdspi_ctrl_mux=0, busy=0.
  - On start=1, latch all cfg_* inputs, set speed=cfg_speed_min, nb=cfg_nb_start, idx=0, mode=(BOTH_MODES ? 0 : cfg_cmd18).
  - If cfg_speed_min>cfg_speed_max or cfg_nb_steps==0, go to FIN. Otherwise go to URST.
- URST:
  - busy=1, sdspi_ctrl_mux=1, sdspi_rst=1 for exactly RST_CYCLES cycles.
  - sdspi_n_blocks, sdspi_sclk_speed and sdspi_cmd18 are stable from URST entry through the end of RUN.
- GO:
  - One cycle with sdspi_rst=0 and sdspi_start=1.
  - Latency counter cleared to 0.
- RUN:
  - Counter increments each cycle.
  - First cycle with sdspi_finish=1: res_cycles=counter value in that cycle (finish seen in the first RUN cycle gives 1), res_timeout=0, go to REPORT.
  - If the counter reaches TIMEOUT with no finish: res_cycles=TIMEOUT, res_timeout=1, go to REPORT.
  - If finish and the timeout occur in the same cycle, finish wins.
- REPORT:
  - res_valid=1; all res_* outputs stable until the cycle where res_ready=1.
  - res_valid drops the next cycle. No new run starts until the record is accepted (backpressure stalls the sweep indefinitely).
- NEXT (single cycle), increments innermost first:
  - Mode: if BOTH_MODES and mode==0, set mode=1 and go to URST.
  - Block count: otherwise set mode=0 (or the fixed mode); if idx+1<steps, set idx+=1, nb=nb+step modulo 2^NB_W (wrap permitted, no saturation), and go to URST.
  - Speed: otherwise set idx=0, nb=start; if speed==speed_max, go to FIN; else set speed+=1 and go to URST.
  - speed_max = all-ones must terminate correctly, with no wrap to 0.
- FIN:
  - done=1 for one cycle, sdspi_rst=1, return to IDLE.
  - Total runs = (max-min+1) × steps × (BOTH_MODES ? 2 : 1).
- abort=1 in any non-IDLE state:
  - Next state is FIN; res_valid drops immediately; any pending record is discarded.
  - done still pulses; sdspi_rst=1 from the next cycle.
- start while busy: ignored.
- cfg_* changes during a sweep: no effect.
- Asynchronous reset mid-run: immediate return to reset values; no partial record is emitted.

Test Plan:
- Single point: min=max=3, nb_start=8, steps=1, BOTH_MODES=0, cmd18=1; UUT model asserts finish 100 cycles after start, res_ready tied 1 -> one record: cycles=100, speed=3, nb=8, cmd18=1, timeout=0; one done pulse; sdspi_rst high 16 cycles before the start pulse.
- Full sweep: min=2, max=4, nb_start=1, step=4, steps=3, BOTH_MODES=1 -> exactly 18 records in the order (2,1,0),(2,1,1),(2,5,0)…(4,9,1), then done.
- Timeout: TIMEOUT=50, finish never asserted -> cycles=50, timeout=1; sweep continues to the next point.
- Backpressure: res_ready held 0 for 200 cycles -> res_valid and fields stable throughout, no sdspi_start pulses; the record is accepted on the first res_ready=1 cycle.
- Boundaries: min=5, max=4 -> done within 2 cycles, no record; max=31 -> terminates after speed 31; nb_start=32'hFFFF_FFFF, step=2, steps=2 -> second nb=1.
- Abort and reset: abort in RUN -> done next cycle, no record, sdspi_rst=1; rst=0 mid-URST -> outputs return to reset values immediately.
